poly_note_player: RTL and testbench
===================================

// Module: poly_note_player
// PURPOSE
//  Parametrised multi-voice successor of the single-voice note player. Holds VOICES independent
//  notes, each with its own beat-driven duration counter and done flag, and mixes their sine
//  outputs into one codec sample stream. Sits between the song/chord sequencer and the codec.
// PARAMETERS
//  VOICES      4   number of simultaneous voices (power of two, 1..8)
//  NOTE_W      6   note index width; note 0 = rest (silent, still timed)
//  DUR_W       6   duration width, in 1/48 s beats
//  SAMPLE_W    16  signed sample width
// PORTS
//  clk                  in   1                  system clock
//  reset                in   1                  synchronous, active-high
//  play_enable          in   1                  1 = play/count, 0 = pause all voices
//  load_new_note        in   1                  1-cycle strobe: load note into voice_sel
//  voice_sel            in   clog2(VOICES)      target voice for load
//  note_to_load         in   NOTE_W             note index
//  duration_to_load     in   DUR_W              length in beats
//  beat                 in   1                  1-cycle 48 Hz tick
//  generate_next_sample in   1                  codec request strobe
//  done_with_note       out  VOICES             per-voice done, level
//  sample_out           out  SAMPLE_W           mixed signed sample
//  new_sample_ready     out  1                  1-cycle strobe, sample_out valid
// BEHAVIOUR
//  Reset: every voice IDLE, remaining=0, done_with_note='1, sample_out=0, new_sample_ready=0.
//  Per-voice FSM: IDLE -> PLAYING on load; PLAYING -> IDLE when remaining hits 0.
//  - Load (load_new_note & voice_sel==v): latch note/duration, remaining<=duration_to_load,
//    done[v]<=0 next cycle; duration 0 -> stays IDLE, done[v] stays 1.
//  - Load to a PLAYING voice retriggers: new note and duration replace old, no done pulse.
//  - PLAYING & beat & play_enable: remaining<=remaining-1; when 1->0, state IDLE, done[v]<=1
//    on the next edge. Beat with play_enable=0 ignored (duration frozen).
//  - Load and final beat in same cycle on same voice: load wins, done stays 0.
//  - Loads to different voices need separate cycles; one load per cycle max.
//  Pitch: per-voice frequency_rom lookup (1-cycle read latency) on latched note; step_size
//   fed to a per-voice sine_reader (existing block). Phase is continuous across notes.
//  Sample path: generate_next_sample forwarded to all sine_readers only when play_enable=1.
//   All readers share latency, so their sample_ready rise together.
//  Mix: voice contributes its sample if PLAYING and note!=0, else 0. Sum sign-extended to
//   SAMPLE_W+clog2(VOICES) bits, sample_out = sum >>> clog2(VOICES) (no clipping possible).
//   sample_out registered; new_sample_ready asserted the cycle after readers' sample_ready.
//  Pause: play_enable=0 -> no requests forwarded, no new_sample_ready, sample_out holds last.
//  Reset mid-note: all voices IDLE, sine_reader phase cleared, pending sample dropped.
// STRUCTURE
//  note_player_defs.vh: NOTE_W/DUR_W/SAMPLE_W defaults, REST_NOTE=0, state encodings.
//  Sub-module note_voice: FSM, remaining counter, done flag, frequency_rom, sine_reader,
//   gated sample output; generate-loop instantiates VOICES copies. Top holds load decode
//   and registered mixer.
// TESTING
//  1. Reset, no loads -> done_with_note=4'b1111, sample_out=0, no new_sample_ready.
//  2. Load v0 note 40 dur 3, 3 beats -> done[0] low until cycle after 3rd beat, then high.
//  3. Load v1 dur 2, play_enable=0 across 5 beats, then 1 for 2 beats -> done[1] after 7th.
//  4. v0 at remaining=1, load v0 dur 4 on same cycle as beat -> done[0] stays 0, 4 more beats.
//  5. v0,v1 same note, v2/v3 idle, request -> sample_out = single-voice sample*2 >>> 2.
//  6. Assert reset mid-note with 2 voices playing -> next cycle all done=1, sample_out=0.

Source files
------------

// File: rtl/poly_note_player_pkg.sv
// poly_note_player_pkg: shared widths, voice state encoding and the pitch/sine tables
package poly_note_player_pkg;
  localparam int NOTE_W_DEF = 6;
  localparam int DUR_W_DEF = 6;
  localparam int SAMPLE_W_DEF = 16;
  localparam int SINE_W = 16;
  localparam int STEP_W = 16;
  localparam int PHASE_W = 18;
  localparam int REST_NOTE = 0;
  typedef enum logic {V_IDLE, V_PLAYING} voice_state_t;
  // Equal-tempered semitone steps for the lowest octave; higher octaves double by shifting.
  function automatic logic [STEP_W-1:0] note_step(input logic [31:0] n);
    logic [STEP_W-1:0] b;
    case (n % 32'd12)
      32'd0: b = 16'd1000;
      32'd1: b = 16'd1059;
      32'd2: b = 16'd1122;
      32'd3: b = 16'd1189;
      32'd4: b = 16'd1260;
      32'd5: b = 16'd1335;
      32'd6: b = 16'd1414;
      32'd7: b = 16'd1498;
      32'd8: b = 16'd1587;
      32'd9: b = 16'd1682;
      32'd10: b = 16'd1782;
      default: b = 16'd1888;
    endcase
    return n == 32'(REST_NOTE) ? '0 : b << (n / 32'd12);
  endfunction
  // First quadrant of a 64-point sine, amplitude 16383.
  function automatic logic signed [SINE_W-1:0] quarter_sine(input logic [4:0] k);
    case (k)
      5'd0: return 16'sd0;
      5'd1: return 16'sd1606;
      5'd2: return 16'sd3196;
      5'd3: return 16'sd4756;
      5'd4: return 16'sd6270;
      5'd5: return 16'sd7723;
      5'd6: return 16'sd9102;
      5'd7: return 16'sd10393;
      5'd8: return 16'sd11585;
      5'd9: return 16'sd12664;
      5'd10: return 16'sd13622;
      5'd11: return 16'sd14449;
      5'd12: return 16'sd15136;
      5'd13: return 16'sd15678;
      5'd14: return 16'sd16068;
      5'd15: return 16'sd16304;
      default: return 16'sd16383;
    endcase
  endfunction
  // Full period from the quarter table by mirroring (bit 4) and negating (bit 5).
  function automatic logic signed [SINE_W-1:0] sine_lut(input logic [5:0] idx);
    logic [4:0] k;
    logic signed [SINE_W-1:0] m;
    k = idx[4] ? 5'd16 - {1'b0, idx[3:0]} : {1'b0, idx[3:0]};
    m = quarter_sine(k);
    return idx[5] ? -m : m;
  endfunction
endpackage

// File: rtl/frequency_rom.sv
// frequency_rom: note index to phase step, one-cycle registered read
module frequency_rom
  import poly_note_player_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF
) (
  input  logic              clk,
  input  logic [NOTE_W-1:0] note,
  output logic [STEP_W-1:0] step_size
);
  // registered table read
  always_ff @(posedge clk) step_size <= note_step(32'(note));
endmodule

// File: rtl/note_voice.sv
// note_voice: one timed note with done flag, pitch lookup and gated sine output
module note_voice
  import poly_note_player_pkg::*;
#(
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [NOTE_W-1:0]        note_in,
  input  logic [DUR_W-1:0]         dur_in,
  input  logic                     beat,
  input  logic                     play_enable,
  input  logic                     sample_req,
  output logic                     done,
  output logic signed [SINE_W-1:0] sample,
  output logic                     sample_ready
);
  voice_state_t state, state_n;
  logic [NOTE_W-1:0] note, note_n;
  logic [DUR_W-1:0] rem, rem_n;
  logic done_n;
  logic [STEP_W-1:0] step;
  logic signed [SINE_W-1:0] raw;
  logic tick;
  assign tick = state == V_PLAYING && beat && play_enable;
  // next state: a load always wins over a same-cycle final beat
  always_comb begin
    state_n = state;
    note_n = note;
    rem_n = rem;
    done_n = done;
    if (load) begin
      note_n = note_in;
      rem_n = dur_in;
      state_n = dur_in != '0 ? V_PLAYING : V_IDLE;
      done_n = dur_in == '0;
    end else if (tick) begin
      rem_n = rem - 1'b1;
      state_n = rem == DUR_W'(1) ? V_IDLE : state;
      done_n = rem == DUR_W'(1);
    end
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= V_IDLE;
      note <= '0;
      rem <= '0;
      done <= 1'b1;
    end else begin
      state <= state_n;
      note <= note_n;
      rem <= rem_n;
      done <= done_n;
    end
  end
  frequency_rom #(.NOTE_W(NOTE_W)) u_rom (
    .clk       (clk),
    .note      (note),
    .step_size (step)
  );
  sine_reader u_sine (
    .clk           (clk),
    .rst           (rst),
    .step_size     (step),
    .generate_next (sample_req),
    .sample        (raw),
    .sample_ready  (sample_ready)
  );
  assign sample = state == V_PLAYING && note != NOTE_W'(REST_NOTE) ? raw : '0;
endmodule

// File: rtl/sine_reader.sv
// sine_reader: phase accumulator plus sine table, sample_ready two cycles after a request
module sine_reader
  import poly_note_player_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STEP_W-1:0]        step_size,
  input  logic                     generate_next,
  output logic signed [SINE_W-1:0] sample,
  output logic                     sample_ready
);
  logic [PHASE_W-1:0] phase;
  logic req_d;
  // advance phase on request, read the table from the advanced phase one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      req_d <= 1'b0;
      sample_ready <= 1'b0;
      sample <= '0;
    end else begin
      if (generate_next) phase <= phase + PHASE_W'(step_size);
      req_d <= generate_next;
      sample_ready <= req_d;
      if (req_d) sample <= sine_lut(phase[PHASE_W-1 -: 6]);
    end
  end
endmodule

// File: rtl/poly_note_player.sv
// poly_note_player: VOICES timed voices with load decode and a registered averaging mixer
module poly_note_player
  import poly_note_player_pkg::*;
#(
  parameter int VOICES = 4,
  parameter int NOTE_W = NOTE_W_DEF,
  parameter int DUR_W = DUR_W_DEF,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  localparam int VS_W = VOICES > 1 ? $clog2(VOICES) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic                       load_new_note,
  input  logic [VS_W-1:0]            voice_sel,
  input  logic [NOTE_W-1:0]          note_to_load,
  input  logic [DUR_W-1:0]           duration_to_load,
  input  logic                       beat,
  input  logic                       generate_next_sample,
  output logic [VOICES-1:0]          done_with_note,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       new_sample_ready
);
  localparam int LG = $clog2(VOICES);
  localparam int SUM_W = SAMPLE_W + LG;
  logic signed [SINE_W-1:0] v_sample [VOICES];
  logic [VOICES-1:0] ready;
  logic signed [SUM_W-1:0] sum;
  logic req;
  assign req = generate_next_sample && play_enable;
  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    note_voice #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) u_voice (
      .clk          (clk),
      .rst          (reset),
      .load         (load_new_note && voice_sel == VS_W'(v)),
      .note_in      (note_to_load),
      .dur_in       (duration_to_load),
      .beat         (beat),
      .play_enable  (play_enable),
      .sample_req   (req),
      .done         (done_with_note[v]),
      .sample       (v_sample[v]),
      .sample_ready (ready[v])
    );
  end
  // sign-extended sum of all gated voice samples; dividing by VOICES cannot overflow
  always_comb begin
    sum = '0;
    for (int i = 0; i < VOICES; i++) sum = sum + SUM_W'(v_sample[i]);
  end
  // register the mix when the readers deliver, unless paused
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out <= '0;
      new_sample_ready <= 1'b0;
    end else begin
      new_sample_ready <= |ready && play_enable;
      if (|ready && play_enable) sample_out <= SAMPLE_W'(sum >>> LG);
    end
  end
endmodule

// File: tb/tb_poly_note_player.sv
// tb_poly_note_player: directed vectors, corner sequences and randomized run against a reference model
module tb_poly_note_player;
  localparam int V = 4;
  logic clk = 1'b0;
  logic reset, play_enable, load_new_note, beat, generate_next_sample;
  logic [1:0] voice_sel;
  logic [5:0] note_to_load, duration_to_load;
  logic [V-1:0] done_with_note;
  logic signed [15:0] sample_out;
  logic new_sample_ready;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  poly_note_player dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .load_new_note        (load_new_note),
    .voice_sel            (voice_sel),
    .note_to_load         (note_to_load),
    .duration_to_load     (duration_to_load),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .done_with_note       (done_with_note),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready)
  );
  typedef struct packed {
    int due;
    logic [V-1:0][17:0] ph;
  } pend_t;
  bit m_play [V];
  int m_note [V];
  int m_rem [V];
  int m_phase [V];
  logic [V-1:0] m_done;
  int m_sample;
  bit m_nsr;
  int cyc;
  pend_t pq [$];
  function automatic int note_ref(int n);
    if (n == 0) return 0;
    return $rtoi(1000.0 * $pow(2.0, (n % 12) / 12.0) + 0.5) << (n / 12);
  endfunction
  function automatic int sine_ref(int ph);
    int idx;
    real x;
    idx = (ph >> 12) & 63;
    x = 16383.0 * $sin(2.0 * 3.14159265358979 * idx / 64.0);
    return x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction
  task automatic chk(string name, int act, int exp, int tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic model_edge();
    pend_t p;
    int sum;
    if (reset) begin
      for (int v = 0; v < V; v++) begin
        m_play[v] = 0;
        m_note[v] = 0;
        m_rem[v] = 0;
        m_phase[v] = 0;
      end
      m_done = '1;
      m_sample = 0;
      m_nsr = 0;
      pq.delete();
      cyc++;
      return;
    end
    m_nsr = 0;
    if (pq.size() > 0 && pq[0].due == cyc) begin
      p = pq.pop_front();
      if (play_enable) begin
        sum = 0;
        for (int v = 0; v < V; v++)
          if (m_play[v] && m_note[v] != 0) sum += sine_ref(int'(p.ph[v]));
        m_sample = sum >>> 2;
        m_nsr = 1;
      end
    end
    if (generate_next_sample && play_enable) begin
      p.due = cyc + 2;
      for (int v = 0; v < V; v++) begin
        m_phase[v] = (m_phase[v] + note_ref(m_note[v])) & 'h3ffff;
        p.ph[v] = 18'(m_phase[v]);
      end
      pq.push_back(p);
    end
    for (int v = 0; v < V; v++) begin
      if (load_new_note && int'(voice_sel) == v) begin
        m_note[v] = int'(note_to_load);
        m_rem[v] = int'(duration_to_load);
        m_play[v] = duration_to_load != 0;
        m_done[v] = duration_to_load == 0;
      end else if (m_play[v] && beat && play_enable) begin
        m_rem[v]--;
        if (m_rem[v] == 0) begin
          m_play[v] = 0;
          m_done[v] = 1;
        end
      end
    end
    cyc++;
  endtask
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("done", int'(done_with_note), int'(m_done), 0);
    chk("nsr", int'(new_sample_ready), int'(m_nsr), 0);
    chk("sample", int'(sample_out), m_sample, 2);
  endtask
  task automatic idle_inputs();
    load_new_note = 0;
    beat = 0;
    generate_next_sample = 0;
    voice_sel = 0;
    note_to_load = 0;
    duration_to_load = 0;
  endtask
  task automatic do_load(int sel, int note, int dur);
    idle_inputs();
    load_new_note = 1;
    voice_sel = 2'(sel);
    note_to_load = 6'(note);
    duration_to_load = 6'(dur);
    cycle();
    load_new_note = 0;
  endtask
  typedef struct {
    bit ld;
    int sel;
    int note;
    int dur;
    bit bt;
    bit en;
    logic [3:0] exp_done;
  } vec_t;
  vec_t vt [$];
  initial begin
    int k, since_load, exp_mix;
    bit got;
    cyc = 0;
    idle_inputs();
    play_enable = 1;
    reset = 1;
    cycle();
    cycle();
    reset = 0;
    cycle();
    chk("rst_done", int'(done_with_note), 15, 0);
    chk("rst_sample", int'(sample_out), 0, 0);
    chk("rst_nsr", int'(new_sample_ready), 0, 0);
    vt.push_back('{1, 0, 40, 3, 0, 1, 4'b1110});
    vt.push_back('{0, 0, 0, 0, 1, 1, 4'b1110});
    vt.push_back('{0, 0, 0, 0, 0, 1, 4'b1110});
    vt.push_back('{0, 0, 0, 0, 1, 1, 4'b1110});
    vt.push_back('{0, 0, 0, 0, 1, 1, 4'b1111});
    vt.push_back('{1, 1, 20, 2, 0, 1, 4'b1101});
    for (int i = 0; i < 5; i++) vt.push_back('{0, 0, 0, 0, 1, 0, 4'b1101});
    vt.push_back('{0, 0, 0, 0, 1, 1, 4'b1101});
    vt.push_back('{0, 0, 0, 0, 1, 1, 4'b1111});
    vt.push_back('{1, 0, 40, 2, 0, 1, 4'b1110});
    vt.push_back('{0, 0, 0, 0, 1, 1, 4'b1110});
    vt.push_back('{1, 0, 40, 4, 1, 1, 4'b1110});
    for (int i = 0; i < 3; i++) vt.push_back('{0, 0, 0, 0, 1, 1, 4'b1110});
    vt.push_back('{0, 0, 0, 0, 1, 1, 4'b1111});
    vt.push_back('{1, 2, 9, 0, 0, 1, 4'b1111});
    vt.push_back('{1, 3, 12, 1, 0, 1, 4'b0111});
    vt.push_back('{1, 3, 30, 2, 0, 1, 4'b0111});
    vt.push_back('{0, 0, 0, 0, 1, 1, 4'b0111});
    vt.push_back('{0, 0, 0, 0, 1, 1, 4'b1111});
    vt.push_back('{1, 2, 5, 1, 1, 1, 4'b1011});
    vt.push_back('{0, 0, 0, 0, 1, 1, 4'b1111});
    foreach (vt[i]) begin
      idle_inputs();
      load_new_note = vt[i].ld;
      voice_sel = 2'(vt[i].sel);
      note_to_load = 6'(vt[i].note);
      duration_to_load = 6'(vt[i].dur);
      beat = vt[i].bt;
      play_enable = vt[i].en;
      cycle();
      chk($sformatf("vec%0d", i), int'(done_with_note), int'(vt[i].exp_done), 0);
    end
    idle_inputs();
    play_enable = 1;
    reset = 1;
    cycle();
    reset = 0;
    do_load(0, 40, 63);
    do_load(1, 40, 63);
    cycle();
    cycle();
    generate_next_sample = 1;
    cycle();
    generate_next_sample = 0;
    k = 0;
    got = 0;
    while (!got && k < 8) begin
      cycle();
      got = new_sample_ready;
      k++;
    end
    chk("mix_ready", int'(got), 1, 0);
    exp_mix = (2 * sine_ref(note_ref(40))) >>> 2;
    if (got) chk("mix_two_voices", int'(sample_out), exp_mix, 2);
    play_enable = 0;
    generate_next_sample = 1;
    cycle();
    generate_next_sample = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("pause_no_ready", int'(new_sample_ready), 0, 0);
      chk("pause_hold", int'(sample_out), exp_mix, 2);
    end
    play_enable = 1;
    generate_next_sample = 1;
    cycle();
    generate_next_sample = 0;
    reset = 1;
    cycle();
    reset = 0;
    chk("midrst_done", int'(done_with_note), 15, 0);
    chk("midrst_sample", int'(sample_out), 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("midrst_dropped", int'(new_sample_ready), 0, 0);
    end
    since_load = 0;
    for (int i = 0; i < 1500; i++) begin
      idle_inputs();
      reset = $urandom_range(0, 199) == 0;
      play_enable = $urandom_range(0, 99) < 85;
      beat = $urandom_range(0, 3) == 0;
      generate_next_sample = since_load >= 3 && $urandom_range(0, 2) == 0;
      load_new_note = $urandom_range(0, 5) == 0;
      voice_sel = 2'($urandom_range(0, 3));
      note_to_load = 6'($urandom_range(0, 63));
      duration_to_load = 6'($urandom_range(0, 7));
      since_load = load_new_note || reset ? 0 : since_load + 1;
      cycle();
    end
    reset = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
